fft_result_reader: RTL and testbench
====================================

FFT_RESULT_READER -- requirements
Module: fft_result_reader

Interface
REQ-001 Parameter bit_width, default 16, SHALL set the width of each real and imaginary component (signed Q1.15).
REQ-002 Parameter L, default 9, SHALL set the number of FFT layers; frame length N = 2^L.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 start  input  1  SHALL request readout of one complete frame.
REQ-006 ram_addr  output  L  SHALL be the result-RAM read address.
REQ-007 ram_rd_data  input  2*bit_width  SHALL be the RAM read data {re, im}, valid exactly one cycle after ram_addr is presented.
REQ-008 out_data  output  2*bit_width  SHALL be the streamed complex bin {re, im}.
REQ-009 out_mag  output  2*bit_width  SHALL be the unsigned re^2 + im^2 of out_data.
REQ-010 out_index  output  L  SHALL be the natural-order bin number k of out_data.
REQ-011 out_valid  output  1  SHALL mark out_data, out_mag and out_index as valid.
REQ-012 out_ready  input  1  SHALL be the consumer's acceptance signal.
REQ-013 busy  output  1  SHALL be high from start acceptance until the final bin handshakes.
REQ-014 done  output  1  SHALL pulse high for one cycle on the cycle after bin N-1 handshakes.

Function
REQ-015 The FSM SHALL have the states IDLE, READ and DRAIN.
- IDLE -> READ on start.
- READ -> DRAIN after the read for k = N-1 is issued.
- DRAIN -> IDLE when bin N-1 handshakes.
REQ-016 start SHALL be ignored in READ and DRAIN.
REQ-017 For natural index k, ram_addr SHALL equal the L-bit bit-reversal of k, so that bins emerge in order k = 0..N-1.
REQ-018 A handshake SHALL occur when out_valid and out_ready are both high on a rising edge.
REQ-019 While out_valid is high and out_ready is low, out_data, out_mag and out_index SHALL hold stable.
REQ-020 Output buffering SHALL be a 2-entry FIFO.
- A read SHALL issue only if (FIFO occupancy + reads in flight) < 2.
- The FIFO SHALL never overflow.
REQ-021 With out_ready held high, the block SHALL sustain one bin per cycle.
REQ-022 The first out_valid SHALL assert 2 cycles after the start-accept edge.
REQ-023 out_mag SHALL be computed with full-precision signed squares, unsigned sum, and no rounding.
- re = im = -32768 SHALL give 0x8000_0000.
REQ-024 out_mag SHALL be registered alongside its bin and add no latency beyond REQ-022.
REQ-025 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-026 The k counter SHALL NOT wrap.
- After the read for k = N-1, no further reads SHALL issue until the next start.
REQ-027 ram_addr SHALL hold its last value when no read is issued.

Reset
REQ-028 On reset, the following SHALL take the stated values:
- FSM = IDLE
- k = 0
- FIFO empty, no reads in flight
- out_valid = 0, busy = 0, done = 0
- ram_addr = 0, out_data = 0, out_mag = 0, out_index = 0
REQ-029 Reset mid-frame SHALL abort the frame; the partially read frame SHALL NOT resume.
REQ-030 A start on the first edge after reset deassertion SHALL be accepted.

Structure
REQ-031 Package fft_pkg SHALL hold:
- bit_width, L, N
- typedef complex_t: packed {re, im} of signed bit_width
REQ-032 Address generation SHALL instantiate the existing reindex_bits sub-module (parameter L) on k.
REQ-033 The FIFO and the magnitude datapath SHALL be internal to fft_result_reader; no other sub-module.

Verification (bench at L = 3, N = 8, RAM preloaded at address a with {re = a, im = -a})
REQ-034 Ordering: start with out_ready = 1 -> ram_addr sequence 0,4,2,6,1,5,3,7; out_index 0..7 on consecutive cycles; done pulses once.
REQ-035 Backpressure: out_ready = 0 for cycles 3-6 -> outputs frozen; no lost or duplicated bin; FIFO occupancy never exceeds 2.
REQ-036 Magnitude: RAM word {0x4000, 0xC000} -> out_mag = 0x2000_0000; {0x8000, 0x8000} -> 0x8000_0000.
REQ-037 Start while busy: second start pulse at bin 3 -> ignored; exactly 8 handshakes, one done pulse.
REQ-038 Reset mid-frame: reset asserted after bin 4 handshakes -> out_valid falls asynchronously; next start streams from k = 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result readout path.
package fft_pkg;

  localparam int bit_width = 16;
  localparam int L         = 9;
  localparam int N         = 1 << L;

  typedef struct packed {
    logic signed [bit_width-1:0] re;
    logic signed [bit_width-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/reindex_bits.sv
// L-bit bit reversal: maps a natural-order bin number to its RAM address.
module reindex_bits #(
  parameter int L = 9
) (
  input  logic [L-1:0] i_bits,
  output logic [L-1:0] o_bits
);

  // Mirror the bit order of the input index.
  always_comb begin
    o_bits = '0;
    for (int i = 0; i < L; i++) begin
      o_bits[i] = i_bits[L-1-i];
    end
  end

endmodule

// File: rtl/fft_result_reader.sv
// Streams one FFT frame out of the bit-reversed result RAM in natural order,
// with a 2-entry output FIFO and a registered |X|^2 alongside each bin.
module fft_result_reader #(
  parameter int bit_width = fft_pkg::bit_width,
  parameter int L         = fft_pkg::L
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [L-1:0]           ram_addr,
  input  logic [2*bit_width-1:0] ram_rd_data,
  output logic [2*bit_width-1:0] out_data,
  output logic [2*bit_width-1:0] out_mag,
  output logic [L-1:0]           out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [L-1:0] K_LAST = '1;

  // Full-precision squared magnitude; each square is non-negative and at
  // most 2^(2W-2), so the unsigned 2W-bit sum cannot overflow.
  function automatic logic [2*bit_width-1:0] f_mag(input logic [2*bit_width-1:0] w);
    logic signed [bit_width-1:0]   v_re;
    logic signed [bit_width-1:0]   v_im;
    logic signed [2*bit_width-1:0] v_re_sq;
    logic signed [2*bit_width-1:0] v_im_sq;
    v_re    = w[2*bit_width-1:bit_width];
    v_im    = w[bit_width-1:0];
    v_re_sq = (2*bit_width)'(v_re) * (2*bit_width)'(v_re);
    v_im_sq = (2*bit_width)'(v_im) * (2*bit_width)'(v_im);
    return unsigned'(v_re_sq) + unsigned'(v_im_sq);
  endfunction

  fft_pkg::rd_state_t r_state, w_state_nxt;

  logic [L-1:0]           r_k;
  logic [L-1:0]           w_rev;
  logic [L-1:0]           r_ram_addr;
  logic [L-1:0]           r_if_idx;
  logic                   r_inflight;
  logic [2*bit_width-1:0] r_fd [2];
  logic [2*bit_width-1:0] r_fm [2];
  logic [L-1:0]           r_fi [2];
  logic                   r_wp;
  logic                   r_rp;
  logic [1:0]             r_cnt;
  logic                   r_done;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_issue;
  logic                   w_accept;
  logic                   w_space;
  logic                   w_last_pop;
  logic [2:0]             w_eff;

  reindex_bits #(.L(L)) u_reindex (
    .i_bits (r_k),
    .o_bits (w_rev)
  );

  assign out_valid  = (r_cnt != 2'd0);
  assign out_data   = r_fd[r_rp];
  assign out_mag    = r_fm[r_rp];
  assign out_index  = r_fi[r_rp];
  assign ram_addr   = r_ram_addr;
  assign busy       = (r_state != fft_pkg::ST_IDLE);
  assign done       = r_done;

  assign w_pop      = out_valid & out_ready;
  assign w_push     = r_inflight;
  assign w_last_pop = w_pop && (out_index == K_LAST);
  // Occupancy seen by a new read counts the slot freed by a same-cycle pop,
  // which is what lets the stream run at one bin per cycle with 2 entries.
  assign w_eff      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_space    = (w_eff < 3'd2);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= fft_pkg::ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and read-issue decision.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      fft_pkg::ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = fft_pkg::ST_READ;
        end
      end
      fft_pkg::ST_READ: begin
        if (w_space) begin
          w_issue = 1'b1;
          if (r_k == K_LAST) w_state_nxt = fft_pkg::ST_DRAIN;
        end
      end
      fft_pkg::ST_DRAIN: begin
        if (w_last_pop) w_state_nxt = fft_pkg::ST_IDLE;
      end
      default: w_state_nxt = fft_pkg::ST_IDLE;
    endcase
  end

  // Bin counter and RAM address; the counter stops at N-1 and the address
  // holds whenever no read is issued. Read data returns on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k        <= '0;
      r_ram_addr <= '0;
      r_if_idx   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_k <= '0;
      end else if (w_issue) begin
        r_ram_addr <= w_rev;
        r_if_idx   <= r_k;
        if (r_k != K_LAST) r_k <= r_k + 1'b1;
      end
    end
  end

  // Output FIFO: bin, magnitude and index are written together on return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fd[i] <= '0;
        r_fm[i] <= '0;
        r_fi[i] <= '0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fd[r_wp] <= ram_rd_data;
        r_fm[r_wp] <= f_mag(ram_rd_data);
        r_fi[r_wp] <= r_if_idx;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // One-cycle completion pulse after the final bin is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_last_pop;
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader at L = 3 (N = 8).
module tb_fft_result_reader;

  localparam int NN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        out_ready;
  logic [2:0]  ram_addr;
  logic [31:0] ram_rd_data;
  logic [31:0] out_data;
  logic [31:0] out_mag;
  logic [2:0]  out_index;
  logic        out_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:NN-1];
  int          rev_tab [NN] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // RAM: address registered inside the DUT, data seen on the following edge.
  assign ram_rd_data = mem[ram_addr];

  fft_result_reader #(.bit_width(16), .L(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .out_data    (out_data),
    .out_mag     (out_mag),
    .out_index   (out_index),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  task automatic init_mem();
    for (int a = 0; a < NN; a++) mem[a] = {16'(a), 16'(-a)};
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    init_mem();
    repeat (3) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
    n_cmp++; if (ram_addr !== 3'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", ram_addr); end
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", out_data); end
    n_cmp++; if (out_mag !== 32'd0) begin n_err++; $display("FAIL reset_mag got %h want 0", out_mag); end
    n_cmp++; if (out_index !== 3'd0) begin n_err++; $display("FAIL reset_index got %0d want 0", out_index); end
    reset = 1'b0;
  endtask

  // Start is raised in the same low phase that reset falls, so it lands on
  // the first edge after deassertion.
  task automatic test_order();
    logic [2:0]  exp_addr;
    logic        exp_v;
    logic [31:0] exp_d;
    logic [31:0] exp_m;
    int          r;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL order_busy_accept got %0b want 1", busy); end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      exp_addr = (c <= 8) ? 3'(rev_tab[c-1]) : 3'd7;
      n_cmp++; if (ram_addr !== exp_addr) begin n_err++; $display("FAIL order_addr c=%0d got %0d want %0d", c, ram_addr, exp_addr); end
      exp_v = (c >= 2 && c <= 9);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL order_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        r     = rev_tab[c-2];
        exp_d = {16'(r), 16'(-r)};
        exp_m = 32'(2 * r * r);
        n_cmp++; if (out_index !== 3'(c-2)) begin n_err++; $display("FAIL order_index c=%0d got %0d want %0d", c, out_index, c-2); end
        n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL order_data c=%0d got %h want %h", c, out_data, exp_d); end
        n_cmp++; if (out_mag !== exp_m) begin n_err++; $display("FAIL order_mag c=%0d got %h want %h", c, out_mag, exp_m); end
      end
      n_cmp++; if (done !== (c == 10)) begin n_err++; $display("FAIL order_done c=%0d got %0b want %0b", c, done, (c == 10)); end
      n_cmp++; if (busy !== (c < 10)) begin n_err++; $display("FAIL order_busy c=%0d got %0b want %0b", c, busy, (c < 10)); end
    end
  endtask

  task automatic test_backpressure();
    int          exp_k = 0;
    int          dones = 0;
    logic        stalled = 1'b0;
    logic [31:0] held_d = '0;
    logic [2:0]  held_i = '0;
    logic [31:0] exp_d;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid) begin
        if (exp_k >= NN) begin
          n_cmp++; n_err++; $display("FAIL bp_extra_bin got index %0d want none", out_index);
        end else begin
          exp_d = {16'(rev_tab[exp_k]), 16'(-rev_tab[exp_k])};
          n_cmp++; if (out_index !== 3'(exp_k)) begin n_err++; $display("FAIL bp_index got %0d want %0d", out_index, exp_k); end
          n_cmp++; if (out_data !== exp_d) begin n_err++; $display("FAIL bp_data got %h want %h", out_data, exp_d); end
        end
        if (stalled) begin
          n_cmp++; if (out_data !== held_d) begin n_err++; $display("FAIL bp_hold_data got %h want %h", out_data, held_d); end
          n_cmp++; if (out_index !== held_i) begin n_err++; $display("FAIL bp_hold_index got %0d want %0d", out_index, held_i); end
        end
      end else if (stalled) begin
        n_cmp++; n_err++; $display("FAIL bp_valid_dropped got 0 want 1");
      end
      n_cmp++; if (dut.r_cnt > 2'd2) begin n_err++; $display("FAIL bp_occupancy got %0d want <=2", dut.r_cnt); end
      if (done) dones++;
      out_ready = !(c >= 3 && c <= 6);
      stalled   = out_valid && !out_ready;
      held_d    = out_data;
      held_i    = out_index;
      if (out_valid && out_ready) exp_k++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    n_cmp++; if (exp_k != NN) begin n_err++; $display("FAIL bp_bin_count got %0d want %0d", exp_k, NN); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL bp_done_count got %0d want 1", dones); end
  endtask

  task automatic test_magnitude();
    logic seen0 = 1'b0;
    logic seen1 = 1'b0;
    mem[0] = {16'h4000, 16'hC000};
    mem[4] = {16'h8000, 16'h8000};
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 3'd0 && !seen0) begin
        seen0 = 1'b1;
        n_cmp++; if (out_data !== 32'h4000_C000) begin n_err++; $display("FAIL mag_data0 got %h want 4000c000", out_data); end
        n_cmp++; if (out_mag !== 32'h2000_0000) begin n_err++; $display("FAIL mag_half got %h want 20000000", out_mag); end
      end
      if (out_valid && out_index == 3'd1 && !seen1) begin
        seen1 = 1'b1;
        n_cmp++; if (out_mag !== 32'h8000_0000) begin n_err++; $display("FAIL mag_minmin got %h want 80000000", out_mag); end
      end
    end
    n_cmp++; if ({seen0, seen1} !== 2'b11) begin n_err++; $display("FAIL mag_bins_seen got %b want 11", {seen0, seen1}); end
    init_mem();
  endtask

  task automatic test_start_busy();
    int   hs = 0;
    int   dones = 0;
    logic pulsed = 1'b0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (out_valid && out_ready) hs++;
      if (done) dones++;
      if (out_valid && out_index == 3'd3 && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++; if (hs != NN) begin n_err++; $display("FAIL busy_handshakes got %0d want %0d", hs, NN); end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL busy_done_count got %0d want 1", dones); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_final got %0b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL busy_no_second_frame got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_midframe();
    logic found = 1'b0;
    int   exp_k = 0;
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_index == 3'd4) found = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rst_mid_bin4_timeout got none want bin 4"); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %0b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %0b want 0", busy); end
    n_cmp++; if (ram_addr !== 3'd0) begin n_err++; $display("FAIL rst_mid_addr got %0d want 0", ram_addr); end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_k >= NN) begin
          n_cmp++; n_err++; $display("FAIL rst_mid_extra_bin got index %0d want none", out_index);
        end else begin
          n_cmp++; if (out_index !== 3'(exp_k)) begin n_err++; $display("FAIL rst_mid_index got %0d want %0d", out_index, exp_k); end
          n_cmp++; if (out_data !== {16'(rev_tab[exp_k]), 16'(-rev_tab[exp_k])}) begin
            n_err++; $display("FAIL rst_mid_data got %h want %h", out_data, {16'(rev_tab[exp_k]), 16'(-rev_tab[exp_k])});
          end
        end
        exp_k++;
      end
    end
    n_cmp++; if (exp_k != NN) begin n_err++; $display("FAIL rst_mid_bin_count got %0d want %0d", exp_k, NN); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_magnitude();
    test_start_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
